// File: rtl/bennett_clock_monitor_if.sv
// Bundle between a ramp generator (master) and the clock monitor (slave).
// Rails and ramp flags flow toward the monitor; status and error reports flow back.
interface bennett_clock_monitor_if #(
    parameter int WIDTH = 11,
    parameter int CNT_W = 16
);
    localparam int LW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] clkn;
    logic [WIDTH-1:0] clkp;
    logic             Fclk;
    logic             instFlag;

    logic             locked;
    logic [LW-1:0]    level;
    logic             ramp_dir;
    logic             cycle_done;
    logic [CNT_W-1:0] cycle_count;
    logic             err;
    logic             err_sticky;
    logic [2:0]       err_code;

    modport master (
        output clkn, clkp, Fclk, instFlag,
        input  locked, level, ramp_dir, cycle_done, cycle_count, err, err_sticky, err_code
    );

    modport slave (
        input  clkn, clkp, Fclk, instFlag,
        output locked, level, ramp_dir, cycle_done, cycle_count, err, err_sticky, err_code
    );
endinterface

// File: rtl/bennett_clock_monitor.sv
// Checks that a multi-stage clock ramp climbs 1..WIDTH and falls back to 0, counting full cycles.
// One-cycle latency: every output is registered from the sample taken at the same edge; no backpressure.
module bennett_clock_monitor #(
    parameter int WIDTH = 11,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    bennett_clock_monitor_if.slave  mon
);
    localparam int LW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_UP       = 2'd1,
        ST_DOWN     = 2'd2
    } state_t;

    state_t           state_q;
    logic [LW-1:0]    prev_l_q;
    logic             locked_q;
    logic [LW-1:0]    level_q;
    logic             ramp_dir_q;
    logic             cycle_done_q;
    logic [CNT_W-1:0] cycle_count_q;
    logic             err_q;
    logic             err_sticky_q;
    logic [2:0]       err_code_q;

    logic [WIDTH-1:0] active;
    logic [LW-1:0]    level_d;
    logic [LW-1:0]    exp_level;
    logic             thermo_ok;
    logic             at_top;
    logic             at_bot;
    logic             seq_err;
    logic             fclk_err;
    logic             inst_err;
    logic [2:0]       code_d;

    // Anything other than a clean 0/1 rail pair, X/Z included, counts as inactive.
    always_comb begin
        active    = '0;
        level_d   = '0;
        thermo_ok = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            active[i] = (mon.clkn[i] === 1'b0) && (mon.clkp[i] === 1'b1);
            level_d   = level_d + LW'(active[i]);
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (active[i] != (i < int'(level_d))) begin
                thermo_ok = 1'b0;
            end
        end
    end

    always_comb begin
        at_top    = (level_d == LW'(WIDTH));
        at_bot    = (level_d == '0);
        exp_level = '0;
        seq_err   = 1'b0;
        fclk_err  = 1'b0;
        inst_err  = 1'b0;
        case (state_q)
            ST_UP: begin
                exp_level = prev_l_q + LW'(1);
                seq_err   = (level_d != exp_level);
                fclk_err  = (mon.Fclk != at_top);
                inst_err  = mon.instFlag;
            end
            ST_DOWN: begin
                exp_level = prev_l_q - LW'(1);
                seq_err   = (level_d != exp_level);
                fclk_err  = mon.Fclk;
                inst_err  = (mon.instFlag != at_bot);
            end
            default: ;
        endcase
        if (!thermo_ok)    code_d = 3'd1;
        else if (seq_err)  code_d = 3'd2;
        else if (fclk_err) code_d = 3'd3;
        else if (inst_err) code_d = 3'd4;
        else               code_d = 3'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_UNLOCKED;
            prev_l_q      <= '0;
            locked_q      <= 1'b0;
            level_q       <= '0;
            ramp_dir_q    <= 1'b0;
            cycle_done_q  <= 1'b0;
            cycle_count_q <= '0;
            err_q         <= 1'b0;
            err_sticky_q  <= 1'b0;
            err_code_q    <= '0;
        end else begin
            prev_l_q     <= level_d;
            level_q      <= level_d;
            err_q        <= (code_d != 3'd0);
            cycle_done_q <= 1'b0;
            if (code_d != 3'd0) begin
                // Only the first error after reset is kept for diagnosis.
                err_sticky_q <= 1'b1;
                if (!err_sticky_q) begin
                    err_code_q <= code_d;
                end
                state_q    <= ST_UNLOCKED;
                locked_q   <= 1'b0;
                ramp_dir_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_UNLOCKED: begin
                        if (prev_l_q == '0 && level_d == LW'(1) && !mon.instFlag) begin
                            state_q  <= ST_UP;
                            locked_q <= 1'b1;
                        end
                    end
                    ST_UP: begin
                        if (at_top) begin
                            state_q    <= ST_DOWN;
                            ramp_dir_q <= 1'b1;
                        end
                    end
                    ST_DOWN: begin
                        if (at_bot) begin
                            state_q       <= ST_UP;
                            ramp_dir_q    <= 1'b0;
                            cycle_done_q  <= 1'b1;
                            cycle_count_q <= cycle_count_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q  <= ST_UNLOCKED;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mon.locked      = locked_q;
    assign mon.level       = level_q;
    assign mon.ramp_dir    = ramp_dir_q;
    assign mon.cycle_done  = cycle_done_q;
    assign mon.cycle_count = cycle_count_q;
    assign mon.err         = err_q;
    assign mon.err_sticky  = err_sticky_q;
    assign mon.err_code    = err_code_q;
endmodule
